// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the datapath / memory interface: the RAM
//               port status, the responder state encoding and the default
//               load value returned on a failed access.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // Status reported by the memory controller for the unified RAM port
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Responder states, exported so benches can name them
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } resp_state_t;

  // Load value handed back when an access errors out or times out
  localparam logic [31:0] c_errword_default = 32'hBAD1BAD1;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dp_mem_responder
// Description : Serves datapath imem/dmem requests one at a time over a single
//               RAM port (data first), returning a one-cycle ihit/dhit pulse
//               with the load data. Failed or timed-out accesses return
//               ERRWORD and set a sticky memerr flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERRWORD = c_errword_default
) (
  input  logic        CLK,
  input  logic        RST,
  // datapath side
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        memerr
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  resp_state_t        r_state;
  resp_state_t        w_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_store;
  logic               r_wr;       // latched access is a write
  logic               r_isd;      // latched access came from the data side
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_iload;
  logic [31:0]        r_dload;
  logic               r_memerr;

  logic w_in_access;
  logic w_ok;
  logic w_fail;

  assign w_in_access = (r_state == DACC) || (r_state == IACC);
  assign w_ok        = (ramstate == ACCESS);
  // An explicit error, or the last allowed wait cycle passing without ACCESS
  assign w_fail      = !w_ok && ((ramstate == ERROR) || (r_cnt == c_cnt_last));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: data has priority in IDLE; RESP always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (dmemWEN || dmemREN) w_next = DACC;
        else if (imemREN)       w_next = IACC;
      end
      DACC, IACC: begin
        if (w_ok || w_fail) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register and the latched request
  always_comb begin
    ramREN = ((r_state == DACC) && !r_wr) || (r_state == IACC);
    ramWEN = (r_state == DACC) && r_wr;
    dhit   = (r_state == RESP) && r_isd;
    ihit   = (r_state == RESP) && !r_isd;
  end

  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign imemload = r_iload;
  assign dmemload = r_dload;
  assign memerr   = r_memerr;

  // Request latches, wait counter, load registers and sticky error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_isd    <= 1'b0;
      r_cnt    <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
      r_memerr <= 1'b0;
    end else if (r_state == IDLE) begin
      if (dmemWEN || dmemREN) begin
        r_addr  <= dmemaddr;
        r_store <= dmemstore;
        r_wr    <= dmemWEN;
        r_isd   <= 1'b1;
        r_cnt   <= '0;
      end else if (imemREN) begin
        r_addr  <= imemaddr;
        r_wr    <= 1'b0;
        r_isd   <= 1'b0;
        r_cnt   <= '0;
      end
    end else if (w_in_access) begin
      if (w_ok) begin
        if (!r_wr) begin
          if (r_isd) r_dload <= ramload;
          else       r_iload <= ramload;
        end
      end else if (w_fail) begin
        r_memerr <= 1'b1;
        if (!r_wr) begin
          if (r_isd) r_dload <= ERRWORD;
          else       r_iload <= ERRWORD;
        end
      end else if (r_cnt != c_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : dp_mem_responder
`default_nettype wire

// File: tb/tb_dp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_mem_responder
// Description : Directed bench for dp_mem_responder with a transaction-level
//               reference model checked every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_mem_responder;
  import cpu_types_pkg::*;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hBAD1BAD1;

  logic        CLK, RST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  ramstate_t   ramstate;

  dp_mem_responder #(.TIMEOUT(TO), .ERRWORD(ERR)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: one outstanding transaction, described by its kind and
  // how many RAM wait cycles it has spent; a finished transaction shows up
  // as a one-cycle hit in the following cycle.
  typedef struct {
    bit          active;   // RAM access in progress this cycle
    bit          hit;      // completion pulse this cycle
    bit          is_data;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] store;
    int          waited;
  } txn_t;

  txn_t        m;
  bit          m_valid = 1'b0;
  logic [31:0] m_iload, m_dload;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare this cycle's outputs, then advance the model using this
  // cycle's inputs (which the DUT samples at the next rising edge).
  task automatic model_step();
    if (m_valid) begin
      chk("ramREN",   32'(ramREN), 32'(m.active && !m.is_write));
      chk("ramWEN",   32'(ramWEN), 32'(m.active && m.is_write));
      chk("dhit",     32'(dhit),   32'(m.hit && m.is_data));
      chk("ihit",     32'(ihit),   32'(m.hit && !m.is_data));
      if (m.active) chk("ramaddr", ramaddr, m.addr);
      if (m.active && m.is_write) chk("ramstore", ramstore, m.store);
      chk("dmemload", dmemload, m_dload);
      chk("imemload", imemload, m_iload);
      chk("memerr",   32'(memerr), 32'(m_err));
    end
    if (RST) begin
      m_valid  = 1'b1;
      m.active = 1'b0;
      m.hit    = 1'b0;
      m.waited = 0;
      m_iload  = '0;
      m_dload  = '0;
      m_err    = 1'b0;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (m.hit) begin
      m.hit = 1'b0;
    end else if (m.active) begin
      if (ramstate == ACCESS) begin
        if (!m.is_write) begin
          if (m.is_data) m_dload = ramload; else m_iload = ramload;
        end
        m.active = 1'b0; m.hit = 1'b1;
      end else if (ramstate == ERROR || m.waited == TO - 1) begin
        m_err = 1'b1;
        if (!m.is_write) begin
          if (m.is_data) m_dload = ERR; else m_iload = ERR;
        end
        m.active = 1'b0; m.hit = 1'b1;
      end else begin
        m.waited++;
      end
    end else if (dmemREN || dmemWEN) begin
      m.active = 1'b1; m.is_data = 1'b1; m.is_write = dmemWEN;
      m.addr = dmemaddr; m.store = dmemstore; m.waited = 0;
    end else if (imemREN) begin
      m.active = 1'b1; m.is_data = 1'b0; m.is_write = 1'b0;
      m.addr = imemaddr; m.waited = 0;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin : stim
    int n;
    int hits;
    int strobes;
    RST = 1'b1; imemREN = 0; dmemREN = 0; dmemWEN = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE;
    @(posedge CLK); #1;
    tick(); tick();
    RST = 1'b0;

    // reset state
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_dmemload", dmemload, 32'h0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    tick();

    // single read, RAM answers immediately
    dmemREN = 1; dmemaddr = 32'h40; ramstate = ACCESS; ramload = 32'h12345678;
    tick();
    chk("rd_c1_ramREN", 32'(ramREN), 32'd1);
    chk("rd_c1_ramaddr", ramaddr, 32'h40);
    dmemREN = 0;
    tick();
    chk("rd_c2_dhit", 32'(dhit), 32'd1);
    chk("rd_c2_dmemload", dmemload, 32'h12345678);
    tick();

    // priority: write and instruction read together
    imemREN = 1; imemaddr = 32'h100; dmemWEN = 1; dmemaddr = 32'h80;
    dmemstore = 32'hCAFEF00D; ramload = 32'h11112222;
    tick();
    chk("pri_c1_ramWEN", 32'(ramWEN), 32'd1);
    chk("pri_c1_ramstore", ramstore, 32'hCAFEF00D);
    dmemWEN = 0;
    tick();
    chk("pri_c2_dhit", 32'(dhit), 32'd1);
    chk("pri_c2_ihit", 32'(ihit), 32'd0);
    tick(); tick();
    chk("pri_c4_ramaddr", ramaddr, 32'h100);
    imemREN = 0;
    tick();
    chk("pri_c5_ihit", 32'(ihit), 32'd1);
    chk("pri_c5_imemload", imemload, 32'h11112222);
    chk("pri_dmemload_kept", dmemload, 32'h12345678);
    tick();

    // five wait states; request dropped mid-access
    imemREN = 1; imemaddr = 32'h200; ramstate = BUSY; ramload = 32'hA5A5A5A5;
    tick();
    imemREN = 0;
    repeat (5) tick();
    chk("ws_c6_ramREN", 32'(ramREN), 32'd1);
    ramstate = ACCESS;
    tick();
    chk("ws_c7_ihit", 32'(ihit), 32'd1);
    chk("ws_c7_imemload", imemload, 32'hA5A5A5A5);
    tick();

    // held request: one hit and one strobe per three cycles
    dmemREN = 1; dmemaddr = 32'h300; ramload = 32'h0BADF00D;
    hits = 0; strobes = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      hits    += int'(dhit);
      strobes += int'(ramREN);
    end
    chk("held_hits", 32'(hits), 32'd3);
    chk("held_strobes", 32'(strobes), 32'd3);
    dmemREN = 0;
    tick(); tick();

    // timeout: RAM stays BUSY
    dmemREN = 1; dmemaddr = 32'h400; ramstate = BUSY;
    tick();
    dmemREN = 0;
    n = 1;
    while (!dhit && n < 40) begin
      tick();
      n++;
    end
    chk("to_hit_cycle", 32'(n), 32'd17);
    chk("to_dmemload", dmemload, 32'hBAD1BAD1);
    chk("to_memerr", 32'(memerr), 32'd1);
    tick();

    // reset in the middle of an access
    dmemREN = 1; dmemaddr = 32'h500;
    tick();
    dmemREN = 0;
    tick();
    RST = 1;
    tick();
    RST = 0;
    chk("rma_ramREN", 32'(ramREN), 32'd0);
    chk("rma_dhit", 32'(dhit), 32'd0);
    chk("rma_memerr", 32'(memerr), 32'd0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      hits += int'(dhit);
    end
    chk("rma_no_hit", 32'(hits), 32'd0);

    // explicit RAM error on a read
    dmemREN = 1; dmemaddr = 32'h600; ramstate = ERROR;
    tick();
    dmemREN = 0;
    tick();
    chk("err_dhit", 32'(dhit), 32'd1);
    chk("err_dmemload", dmemload, 32'hBAD1BAD1);
    chk("err_memerr", 32'(memerr), 32'd1);
    ramstate = FREE;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_dp_mem_responder
`default_nettype wire
